snow64_instr_cache: RTL
=======================

Name: snow64_instr_cache

Overview:
- Direct-mapped, read-only instruction cache directly upstream of the IF/ID pipe stage.
- Returns one 32-bit instruction per hit with registered 1-cycle latency.
- On a miss, refills a full 256-bit line from the memory arbiter through a req/valid handshake.
- Supports whole-cache invalidation, issued after self-modifying stores or a program load.

Parameters:
NUM_LINES, 16, number of lines; power of two, minimum 2
WIDTH__LINE, 256, line width in bits; 32 bytes, 8 instructions
WIDTH__ADDR, 64, CPU address width
WIDTH__INSTR, 32, instruction width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_req  in  1  fetch request valid (IF/ID drives it high every cycle)
in_addr  in  64  byte address of the requested instruction
in_invalidate  in  1  clear all line valid bits
out_valid  out  1  out_instr holds the instruction for the request sampled on the previous edge
out_instr  out  32  fetched instruction
out_mem_req  out  1  line refill request; held high until in_mem_valid
out_mem_addr  out  64  line-aligned refill address (bits 4:0 = 0)
in_mem_valid  in  1  in_mem_data valid; one-cycle pulse
in_mem_data  in  256  refill line; instruction k is at bits [32k+31:32k]
out_hit_count  out  32  hit counter (optional feature)
out_miss_count  out  32  miss counter (optional feature)

Behaviour:
- Address split:
  - offset = addr[4:0], word select = addr[4:2].
  - index = addr[4+log2(NUM_LINES):5].
  - tag = the remaining upper bits.
  - addr[1:0] is ignored.
- Storage: data array, tag array, and one valid bit per line.
- Reset:
  - All valid bits cleared; state StIdle.
  - out_valid, out_instr, out_mem_req, out_mem_addr and both counters = 0.
- StIdle:
  - If in_req is high and the line hits, next edge: out_valid = 1 and out_instr = the selected word.
  - Otherwise out_valid = 0 next edge.
  - On a miss, next edge: latch the line-aligned address, out_mem_req = 1, go to StRefill.
- StRefill:
  - out_mem_req and out_mem_addr are held stable; out_valid = 0; in_req is ignored.
  - When in_mem_valid is seen, next edge: write data, tag and valid = 1 at the latched index, out_mem_req = 0, go to StIdle.
  - The missed request is not replayed internally. The requester holds or reissues its address, and that lookup hits one cycle later.
  - Miss-to-valid latency = memory latency + 2 cycles.
- A change of in_addr during StRefill (branch redirect) does not abort the refill; the line is still installed.
- in_invalidate:
  - Takes effect at the next edge in any state.
  - In StIdle, a simultaneous lookup gives out_valid = 0, and no refill starts from it.
  - In StRefill, the refill handshake completes, but the line is installed with valid = 0.
- in_invalidate together with in_mem_valid: invalidate wins; the line is not marked valid.
- rst mid-refill:
  - Aborts the refill: out_mem_req drops at the next edge.
  - A late in_mem_valid in StIdle is ignored.
- Line replacement always overwrites (direct-mapped); a tag match on an invalid line is a miss.
- out_instr holds its last value whenever out_valid = 0.

Optional Feature:
- Macro: SNOW64_INSTR_CACHE_PERF_CTR_EN.
- Defined:
  - out_hit_count increments on each StIdle lookup that hits.
  - out_miss_count increments on each StIdle lookup that starts a refill.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and clear on rst only.
- Undefined: no counter logic; both ports are tied to 0.

Test Plan:
- Cold miss: rst, then in_req = 1 with in_addr = 0x0 held; in_mem_valid 3 cycles after out_mem_req, in_mem_data word0 = 0x11111111 → out_mem_addr = 0x0; out_valid = 1 with out_instr = 0x11111111 two cycles after the in_mem_valid edge.
- Sequential hits: after the line at 0x20 is filled with word k = 0xA0+k, step in_addr 0x20..0x3C in steps of 4 each cycle → out_valid = 1 every cycle, out_instr = 0xA0..0xA7, out_mem_req stays 0.
- Conflict eviction: fill 0x0, then request 0x200 (same index with NUM_LINES = 16), then 0x0 again → three refills, each returning the correct data.
- Redirect during refill: miss on 0x40, change in_addr to 0x80 mid-refill → refill of 0x40 completes, a new refill of 0x80 follows, and a later 0x40 request hits with no mem_req.
- Invalidate: pulse in_invalidate while in_mem_valid = 1 for 0x60 → a subsequent 0x60 request misses (out_mem_req = 1); a previously cached 0x0 also misses.
- Perf counters (macro defined): 1 miss + 7 hits on one line → out_hit_count = 7, out_miss_count = 1; with the macro undefined, both read 0.

Source files
------------

// File: rtl/snow64_instr_cache_if.sv
// Fetch-side and refill-side signal bundle for snow64_instr_cache.
// The cache connects through the slave modport; the fetch stage/arbiter model uses master.
interface snow64_instr_cache_if #(
  parameter int WIDTH__LINE  = 256,
  parameter int WIDTH__ADDR  = 64,
  parameter int WIDTH__INSTR = 32
);
  logic                    in_req;
  logic [WIDTH__ADDR-1:0]  in_addr;
  logic                    in_invalidate;
  logic                    out_valid;
  logic [WIDTH__INSTR-1:0] out_instr;
  logic                    out_mem_req;
  logic [WIDTH__ADDR-1:0]  out_mem_addr;
  logic                    in_mem_valid;
  logic [WIDTH__LINE-1:0]  in_mem_data;
  logic [31:0]             out_hit_count;
  logic [31:0]             out_miss_count;

  modport master (
    output in_req, in_addr, in_invalidate, in_mem_valid, in_mem_data,
    input  out_valid, out_instr, out_mem_req, out_mem_addr, out_hit_count, out_miss_count
  );

  modport slave (
    input  in_req, in_addr, in_invalidate, in_mem_valid, in_mem_data,
    output out_valid, out_instr, out_mem_req, out_mem_addr, out_hit_count, out_miss_count
  );
endinterface

// File: rtl/snow64_instr_cache.sv
// Direct-mapped read-only instruction cache with single-line refill over a req/valid handshake.
// Define SNOW64_INSTR_CACHE_PERF_CTR_EN to build the saturating hit/miss counters.
module snow64_instr_cache #(
  parameter int NUM_LINES    = 16,
  parameter int WIDTH__LINE  = 256,
  parameter int WIDTH__ADDR  = 64,
  parameter int WIDTH__INSTR = 32
) (
  input logic                clk,
  input logic                rst,
  snow64_instr_cache_if.slave bus
);
  localparam int WORDS  = WIDTH__LINE / WIDTH__INSTR;
  localparam int OFF_W  = $clog2(WIDTH__LINE / 8);
  localparam int BYTE_W = $clog2(WIDTH__INSTR / 8);
  localparam int WSEL_W = $clog2(WORDS);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = WIDTH__ADDR - OFF_W - IDX_W;

  typedef enum logic {StIdle, StRefill} state_t;

  state_t                  state_q;
  logic [NUM_LINES-1:0]    valid_q;
  logic [WIDTH__LINE-1:0]  data_q [NUM_LINES];
  logic [TAG_W-1:0]        tag_q  [NUM_LINES];
  logic                    out_valid_q;
  logic [WIDTH__INSTR-1:0] out_instr_q;
  logic                    mem_req_q;
  logic [WIDTH__ADDR-1:0]  mem_addr_q;

  logic [IDX_W-1:0]        lk_idx;
  logic [TAG_W-1:0]        lk_tag;
  logic [WSEL_W-1:0]       lk_wsel;
  logic [WIDTH__LINE-1:0]  lk_line;
  logic [WIDTH__INSTR-1:0] lk_words [WORDS];
  logic                    lk_hit;
  logic                    lookup;
  logic [IDX_W-1:0]        rf_idx;
  logic [TAG_W-1:0]        rf_tag;
  logic                    rf_done;

  assign lk_idx  = bus.in_addr[OFF_W +: IDX_W];
  assign lk_tag  = bus.in_addr[WIDTH__ADDR-1 -: TAG_W];
  assign lk_wsel = bus.in_addr[BYTE_W +: WSEL_W];
  assign lk_line = data_q[lk_idx];
  assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
      assign lk_words[gi] = lk_line[gi*WIDTH__INSTR +: WIDTH__INSTR];
    end
  endgenerate

  // Invalidate suppresses the lookup entirely so it can neither hit nor start a refill.
  assign lookup  = (state_q == StIdle) && bus.in_req && !bus.in_invalidate;
  assign rf_idx  = mem_addr_q[OFF_W +: IDX_W];
  assign rf_tag  = mem_addr_q[WIDTH__ADDR-1 -: TAG_W];
  assign rf_done = (state_q == StRefill) && bus.in_mem_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (bus.in_invalidate) valid_q <= '0;
      case (state_q)
        StIdle: begin
          if (lookup) begin
            if (lk_hit) begin
              out_valid_q <= 1'b1;
              out_instr_q <= lk_words[lk_wsel];
            end else begin
              mem_addr_q <= {bus.in_addr[WIDTH__ADDR-1:OFF_W], {OFF_W{1'b0}}};
              mem_req_q  <= 1'b1;
              state_q    <= StRefill;
            end
          end
        end
        StRefill: begin
          if (bus.in_mem_valid) begin
            // A concurrent invalidate still lets the handshake finish but leaves the line unusable.
            valid_q[rf_idx] <= !bus.in_invalidate;
            mem_req_q       <= 1'b0;
            state_q         <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Line payload and tags live in plain arrays without reset; the valid bits gate them.
  always_ff @(posedge clk) begin
    if (!rst && rf_done) begin
      data_q[rf_idx] <= bus.in_mem_data;
      tag_q[rf_idx]  <= rf_tag;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_instr    = out_instr_q;
  assign bus.out_mem_req  = mem_req_q;
  assign bus.out_mem_addr = mem_addr_q;

`ifdef SNOW64_INSTR_CACHE_PERF_CTR_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (lookup && lk_hit && (hit_cnt_q != 32'hFFFF_FFFF))   hit_cnt_d  = hit_cnt_q + 32'd1;
    if (lookup && !lk_hit && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.out_hit_count  = hit_cnt_q;
  assign bus.out_miss_count = miss_cnt_q;
`else
  assign bus.out_hit_count  = 32'd0;
  assign bus.out_miss_count = 32'd0;
`endif
endmodule
